// File: rtl/ram_port_arbiter.sv
// Shares one single-port SRAM between NUM_PORTS req/gnt/rvalid masters; grant is combinational, rvalid one cycle later.
// Backpressure is the grant itself: a requester holds its request until granted, and starvation counters bound the wait.
module ram_port_arbiter #(
  parameter int NUM_PORTS    = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int PRIO_PORT0   = 1,
  parameter int STARVE_LIMIT = 7
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req_i,
  output logic [NUM_PORTS-1:0]             gnt_o,
  output logic [NUM_PORTS-1:0]             rvalid_o,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr_i,
  input  logic [NUM_PORTS-1:0]             we_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata_i,
  output logic [DATA_WIDTH-1:0]            rdata_o,
  output logic                             ram_en_o,
  output logic [ADDR_WIDTH-1:0]            ram_addr_o,
  output logic                             ram_we_o,
  output logic [DATA_WIDTH/8-1:0]          ram_be_o,
  output logic [DATA_WIDTH-1:0]            ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]            ram_rdata_i
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_PORTS - 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [BE_W-1:0]       be;
    logic [DATA_WIDTH-1:0] wdata;
  } ram_req_t;

  logic [IDX_W-1:0]     last_q;
  logic [IDX_W-1:0]     rr_idx;
  logic                 rr_gnt;
  int                   scan_idx;
  logic [CNT_W-1:0]     wait_q [NUM_PORTS];
  logic [NUM_PORTS-1:0] starved;
  logic [NUM_PORTS-1:0] gnt;
  logic [NUM_PORTS-1:0] rvalid_q;
  ram_req_t             port_req [NUM_PORTS];
  ram_req_t             ram_req;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign port_req[p] = '{addr:  addr_i[p*ADDR_WIDTH +: ADDR_WIDTH],
                           we:    we_i[p],
                           be:    be_i[p*BE_W +: BE_W],
                           wdata: wdata_i[p*DATA_WIDTH +: DATA_WIDTH]};
    assign starved[p]  = req_i[p] && (wait_q[p] == LIMIT);
  end

  // Scans run from the far end so the last hit (lowest / nearest) wins.
  always_comb begin
    gnt      = '0;
    rr_gnt   = 1'b0;
    rr_idx   = last_q;
    scan_idx = 0;
    if (|starved) begin
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
        if (starved[p]) gnt = NUM_PORTS'(1) << p;
      end
    end else if (PRIO_PORT0 != 0 && req_i[0]) begin
      gnt[0] = 1'b1;
    end else begin
      for (int k = NUM_PORTS; k >= 1; k--) begin
        scan_idx = (int'(last_q) + k) % NUM_PORTS;
        if (req_i[scan_idx]) begin
          rr_gnt = 1'b1;
          rr_idx = IDX_W'(scan_idx);
        end
      end
      if (rr_gnt) gnt = NUM_PORTS'(1) << rr_idx;
    end
  end

  always_comb begin
    ram_req = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt[p]) ram_req = port_req[p];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= '0;
      last_q   <= LAST_RST;
      for (int p = 0; p < NUM_PORTS; p++) wait_q[p] <= '0;
    end else begin
      rvalid_q <= gnt;
      if (rr_gnt) last_q <= rr_idx;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (!req_i[p] || gnt[p]) wait_q[p] <= '0;
        else if (wait_q[p] != LIMIT) wait_q[p] <= wait_q[p] + CNT_W'(1);
      end
    end
  end

  assign gnt_o       = gnt;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = ram_rdata_i;
  assign ram_en_o    = |req_i;
  assign ram_addr_o  = ram_req.addr;
  assign ram_we_o    = ram_req.we;
  assign ram_be_o    = ram_req.be;
  assign ram_wdata_o = ram_req.wdata;

endmodule
